// File: rtl/router_psum_pkg.sv
// Shared types and sizing helpers for the psum stream router.
package router_psum_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RD,
        ACC
    } state_t;

    localparam int X_DIM      = 5;
    localparam int LANE_IDX_W = $clog2(X_DIM);

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/router_psum_stream_if.sv
// Scratchpad-side push port and GLB-side access port of the psum router.
interface router_psum_stream_if #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int X_dim             = 5
);
    logic [DATA_BITWIDTH*X_dim-1:0] r_data_spad_psum;
    logic                           write_psum_ctrl;
    logic                           accum_mode;
    logic                           psum_ready;
    logic                           glb_ready;
    logic                           read_req_glb_psum;
    logic [ADDR_BITWIDTH_GLB-1:0]   r_addr_glb_psum;
    logic [DATA_BITWIDTH-1:0]       r_data_glb_psum;
    logic                           write_en_glb_psum;
    logic [ADDR_BITWIDTH_GLB-1:0]   w_addr_glb_psum;
    logic [DATA_BITWIDTH-1:0]       w_data_glb_psum;
    logic                           busy;
    logic                           overflow_err;

    modport slave (
        input  r_data_spad_psum, write_psum_ctrl, accum_mode, glb_ready, r_data_glb_psum,
        output psum_ready, read_req_glb_psum, r_addr_glb_psum, write_en_glb_psum,
               w_addr_glb_psum, w_data_glb_psum, busy, overflow_err
    );

    modport master (
        output r_data_spad_psum, write_psum_ctrl, accum_mode, glb_ready, r_data_glb_psum,
        input  psum_ready, read_req_glb_psum, r_addr_glb_psum, write_en_glb_psum,
               w_addr_glb_psum, w_data_glb_psum, busy, overflow_err
    );
endinterface

// File: rtl/psum_vec_fifo.sv
// Vector FIFO with occupancy count; DEPTH must be a power of two (>= 2).
module psum_vec_fifo
    import router_psum_pkg::*;
#(
    parameter int WIDTH = 81,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [idx_bits(DEPTH):0] count
);
    localparam int PTR_W = idx_bits(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop  && (count != '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is not reset; count gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_psum_stream.sv
// Psum stream router: buffers psum vectors and streams them lane by lane into
// the GLB, either overwriting or accumulating via read-modify-write.
module router_psum_stream
    import router_psum_pkg::*;
#(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int X_dim             = X_DIM,
    parameter int FIFO_DEPTH        = 4,
    parameter int PSUM_LOAD_ADDR    = 0,
    parameter int PSUM_REGION       = 256
) (
    input  logic                clk,
    input  logic                reset,
    router_psum_stream_if.slave bus
);
    localparam int VEC_W  = DATA_BITWIDTH * X_dim;
    localparam int LANE_W = idx_bits(X_dim);
    localparam int CNT_W  = idx_bits(FIFO_DEPTH) + 1;
    localparam logic [LANE_W-1:0]            LAST_LANE  = LANE_W'(X_dim - 1);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] ADDR_FIRST = ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] ADDR_LAST  =
        ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR + PSUM_REGION - 1);

    state_t                       state, state_n;
    logic [VEC_W-1:0]             lane_sr;
    logic [LANE_W-1:0]            lane_idx;
    logic [ADDR_BITWIDTH_GLB-1:0] ptr, ptr_next;
    logic                         overflow_q;

    logic [VEC_W:0]               head;
    logic [CNT_W-1:0]             fifo_count;
    logic                         fifo_push, fifo_pop, fifo_nonempty, ready;
    logic                         advance, last_lane;

    logic                         rd_req, wr_en;
    logic [ADDR_BITWIDTH_GLB-1:0] rd_addr, wr_addr;
    logic [DATA_BITWIDTH-1:0]     wr_data;

    // Readiness comes only from the registered count, so a same-cycle pop never frees a slot.
    assign ready         = fifo_count != CNT_W'(FIFO_DEPTH);
    assign fifo_nonempty = fifo_count != '0;
    assign fifo_push     = bus.write_psum_ctrl && ready;
    assign last_lane     = lane_idx == LAST_LANE;
    assign ptr_next      = (ptr == ADDR_LAST) ? ADDR_FIRST : ptr + 1'b1;

    psum_vec_fifo #(
        .WIDTH (VEC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({bus.accum_mode, bus.r_data_spad_psum}),
        .rd_data (head),
        .count   (fifo_count)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        fifo_pop = 1'b0;
        advance  = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        // Strobes are forced low while reset is held so no access escapes mid-reset.
        if (!reset) begin
            unique case (state)
                IDLE: if (fifo_nonempty) state_n = LOAD;
                LOAD: begin
                    fifo_pop = 1'b1;
                    state_n  = head[VEC_W] ? RD : WRITE;
                end
                WRITE: if (bus.glb_ready) begin
                    wr_en   = 1'b1;
                    wr_addr = ptr;
                    wr_data = lane_sr[DATA_BITWIDTH-1:0];
                    advance = 1'b1;
                    if (last_lane) state_n = fifo_nonempty ? LOAD : IDLE;
                end
                RD: if (bus.glb_ready) begin
                    rd_req  = 1'b1;
                    rd_addr = ptr;
                    state_n = ACC;
                end
                ACC: begin
                    wr_en   = 1'b1;
                    wr_addr = ptr;
                    wr_data = lane_sr[DATA_BITWIDTH-1:0] + bus.r_data_glb_psum;
                    advance = 1'b1;
                    state_n = last_lane ? (fifo_nonempty ? LOAD : IDLE) : RD;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lane_sr    <= '0;
            lane_idx   <= '0;
            ptr        <= ADDR_FIRST;
            overflow_q <= 1'b0;
        end else begin
            state <= state_n;
            if (bus.write_psum_ctrl && !ready) overflow_q <= 1'b1;
            if (fifo_pop) begin
                lane_sr  <= head[VEC_W-1:0];
                lane_idx <= '0;
            end else if (advance) begin
                lane_sr  <= lane_sr >> DATA_BITWIDTH;
                lane_idx <= lane_idx + 1'b1;
                ptr      <= ptr_next;
            end
        end
    end

    assign bus.psum_ready        = ready;
    assign bus.read_req_glb_psum = rd_req;
    assign bus.r_addr_glb_psum   = rd_addr;
    assign bus.write_en_glb_psum = wr_en;
    assign bus.w_addr_glb_psum   = wr_addr;
    assign bus.w_data_glb_psum   = wr_data;
    assign bus.busy              = (state != IDLE) || fifo_nonempty;
    assign bus.overflow_err      = overflow_q;

endmodule

// File: tb/tb_router_psum_stream.sv
// Directed bench for router_psum_stream with a 1-cycle-latency GLB model.
`timescale 1ns/1ps
module tb_router_psum_stream;
    localparam int D = 16;
    localparam int A = 10;
    localparam int X = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_psum_stream_if #(.DATA_BITWIDTH(D), .ADDR_BITWIDTH_GLB(A), .X_dim(X)) bus ();

    router_psum_stream #(
        .DATA_BITWIDTH(D), .ADDR_BITWIDTH_GLB(A), .X_dim(X),
        .FIFO_DEPTH(4), .PSUM_LOAD_ADDR(0), .PSUM_REGION(256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int           cyc;
        logic [A-1:0] addr;
        logic [D-1:0] data;
    } access_t;

    access_t      wlog[$];
    access_t      rlog[$];
    logic [D-1:0] glb_mem [1024];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           overlap = 0;
    int           leak = 0;
    logic         rd_pend = 1'b0;
    logic [A-1:0] rd_addr = '0;
    logic         tog = 1'b0;
    logic         gr_level = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [D*X-1:0] vec5(input logic [D-1:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    // Cycle counter and GLB read data, one cycle after the request.
    always @(posedge clk) begin
        cyc++;
        bus.r_data_glb_psum <= rd_pend ? glb_mem[rd_addr] : '0;
        rd_pend = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        bus.glb_ready = tog ? ~bus.glb_ready : gr_level;
    end

    always @(negedge clk) begin
        if (bus.read_req_glb_psum && bus.write_en_glb_psum) overlap++;
        if (!bus.write_en_glb_psum && (bus.w_addr_glb_psum != '0 || bus.w_data_glb_psum != '0)) leak++;
        if (!bus.read_req_glb_psum && bus.r_addr_glb_psum != '0) leak++;
        if (bus.write_en_glb_psum) begin
            glb_mem[bus.w_addr_glb_psum] = bus.w_data_glb_psum;
            wlog.push_back('{cyc, bus.w_addr_glb_psum, bus.w_data_glb_psum});
        end
        if (bus.read_req_glb_psum) begin
            rd_pend = 1'b1;
            rd_addr = bus.r_addr_glb_psum;
            rlog.push_back('{cyc, bus.r_addr_glb_psum, '0});
        end
    end

    task automatic push(input logic [D*X-1:0] v, input logic m, output int t);
        @(posedge clk); #1;
        bus.write_psum_ctrl  = 1'b1;
        bus.r_data_spad_psum = v;
        bus.accum_mode       = m;
        t = cyc;
    endtask

    task automatic push_ready(input logic [D*X-1:0] v, input logic m);
        int n = 0;
        @(posedge clk); #1;
        while (!bus.psum_ready && n < 50) begin
            bus.write_psum_ctrl = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!bus.psum_ready) check("ready_timeout", 32'd0, 32'd1);
        bus.write_psum_ctrl  = 1'b1;
        bus.r_data_spad_psum = v;
        bus.accum_mode       = m;
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        bus.write_psum_ctrl  = 1'b0;
        bus.r_data_spad_psum = '0;
        bus.accum_mode       = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n0, r0, n;
        logic [D-1:0] exp_d;
        bus.write_psum_ctrl  = 1'b0;
        bus.r_data_spad_psum = '0;
        bus.accum_mode       = 1'b0;
        for (int i = 0; i < 1024; i++) glb_mem[i] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",    32'(bus.psum_ready), 32'd1);
        check("rst_busy",     32'(bus.busy), 32'd0);
        check("rst_overflow", 32'(bus.overflow_err), 32'd0);
        check("rst_wen",      32'(bus.write_en_glb_psum), 32'd0);
        check("rst_rreq",     32'(bus.read_req_glb_psum), 32'd0);
        check("rst_waddr",    32'(bus.w_addr_glb_psum), 32'd0);
        check("rst_wdata",    32'(bus.w_data_glb_psum), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Overwrite: latency and one word per cycle.
        n0 = wlog.size();
        push(vec5(16'd1, 16'd2, 16'd3, 16'd4, 16'd5), 1'b0, t);
        drive_idle();
        wait_cyc(t + 8);
        check("t1_busy_t8", 32'(bus.busy), 32'd0);
        check("t1_nwr", 32'(wlog.size() - n0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t1_cyc",  32'(wlog[n0+i].cyc), 32'(t + 3 + i));
            check("t1_addr", 32'(wlog[n0+i].addr), 32'(i));
            check("t1_data", 32'(wlog[n0+i].data), 32'(i + 1));
        end

        // Accumulate with modulo wrap on lane 0.
        for (int i = 5; i < 10; i++) glb_mem[i] = 16'd10;
        n0 = wlog.size();
        r0 = rlog.size();
        push(vec5(16'hFFFF, 16'd1, 16'd1, 16'd1, 16'd1), 1'b1, t);
        drive_idle();
        wait_idle("t2_idle");
        check("t2_nwr", 32'(wlog.size() - n0), 32'd5);
        check("t2_nrd", 32'(rlog.size() - r0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            exp_d = (i == 0) ? 16'd9 : 16'd11;
            check("t2_rd_addr", 32'(rlog[r0+i].addr), 32'(5 + i));
            check("t2_rd_cyc",  32'(rlog[r0+i].cyc), 32'(t + 3 + 2*i));
            check("t2_wr_addr", 32'(wlog[n0+i].addr), 32'(5 + i));
            check("t2_wr_cyc",  32'(wlog[n0+i].cyc), 32'(t + 4 + 2*i));
            check("t2_wr_data", 32'(wlog[n0+i].data), 32'(exp_d));
        end

        // Stall the GLB with one vector in flight, then overrun the FIFO.
        gr_level = 1'b0;
        n0 = wlog.size();
        push(vec5(16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hA4), 1'b0, t);
        drive_idle();
        wait_cyc(t + 4);
        check("t3_stall_nwr", 32'(wlog.size() - n0), 32'd0);
        check("t3_stall_busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            push(vec5(16'(k*256), 16'(k*256+1), 16'(k*256+2), 16'(k*256+3), 16'(k*256+4)), 1'b0, t);
            @(negedge clk);
            check("t3_ready", 32'(bus.psum_ready), (k < 5) ? 32'd1 : 32'd0);
        end
        check("t3_ovf_pre", 32'(bus.overflow_err), 32'd0);
        drive_idle();
        @(negedge clk);
        check("t3_ovf_set", 32'(bus.overflow_err), 32'd1);
        repeat (5) @(negedge clk);
        gr_level = 1'b1;
        wait_idle("t3_idle");
        check("t3_ovf_sticky", 32'(bus.overflow_err), 32'd1);
        check("t3_nwr", 32'(wlog.size() - n0), 32'd25);
        n = 0;
        for (int i = 0; i < 25 && n0 + i < wlog.size(); i++) begin
            exp_d = (i < 5) ? 16'(16'hA0 + i) : 16'(((i-5)/5 + 1)*256 + (i-5)%5);
            if (i >= 5) n++;
            check("t3_addr", 32'(wlog[n0+i].addr), 32'(10 + i));
            check("t3_data", 32'(wlog[n0+i].data), 32'(exp_d));
        end
        check("t3_burst_words", 32'(n), 32'd20);

        pulse_reset(2);
        @(negedge clk);
        check("rst2_overflow", 32'(bus.overflow_err), 32'd0);
        check("rst2_ready", 32'(bus.psum_ready), 32'd1);

        // 102 vectors bring the pointer to 254, then one vector crosses the wrap.
        n0 = wlog.size();
        for (int k = 0; k < 102; k++) push_ready(vec5(16'(k), 16'(k), 16'(k), 16'(k), 16'(k)), 1'b0);
        drive_idle();
        wait_idle("t4_fill_idle");
        check("t4_fill_nwr", 32'(wlog.size() - n0), 32'd510);
        check("t4_fill_ovf", 32'(bus.overflow_err), 32'd0);
        n0 = wlog.size();
        push(vec5(16'h51, 16'h52, 16'h53, 16'h54, 16'h55), 1'b0, t);
        drive_idle();
        wait_idle("t4_idle");
        check("t4_nwr", 32'(wlog.size() - n0), 32'd5);
        for (int i = 0; i < 5 && n0 + i < wlog.size(); i++) begin
            check("t4_addr", 32'(wlog[n0+i].addr), 32'((254 + i) % 256));
            check("t4_data", 32'(wlog[n0+i].data), 32'(16'h51 + i));
        end

        // Toggling glb_ready: every word exactly once, in order.
        tog = 1'b1;
        n0 = wlog.size();
        push(vec5(16'h61, 16'h62, 16'h63, 16'h64, 16'h65), 1'b0, t);
        drive_idle();
        wait_idle("t5_idle");
        check("t5_nwr", 32'(wlog.size() - n0), 32'd5);
        for (int i = 0; i < 5 && n0 + i < wlog.size(); i++) begin
            check("t5_addr", 32'(wlog[n0+i].addr), 32'(3 + i));
            check("t5_data", 32'(wlog[n0+i].data), 32'(16'h61 + i));
        end

        // Reset after the second word of a vector discards the rest.
        n0 = wlog.size();
        push(vec5(16'h71, 16'h72, 16'h73, 16'h74, 16'h75), 1'b0, t);
        drive_idle();
        n = 0;
        while (wlog.size() < n0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5r_two_words", 32'(wlog.size() - n0), 32'd2);
        pulse_reset(2);
        repeat (10) @(negedge clk);
        check("t5r_no_more", 32'(wlog.size() - n0), 32'd2);
        check("t5r_busy", 32'(bus.busy), 32'd0);
        tog = 1'b0;
        gr_level = 1'b1;
        @(posedge clk);
        n0 = wlog.size();
        push(vec5(16'h81, 16'h82, 16'h83, 16'h84, 16'h85), 1'b0, t);
        drive_idle();
        wait_idle("t5p_idle");
        check("t5p_nwr", 32'(wlog.size() - n0), 32'd5);
        if (wlog.size() > n0) begin
            check("t5p_addr0", 32'(wlog[n0].addr), 32'd0);
            check("t5p_data0", 32'(wlog[n0].data), 32'h81);
        end

        check("strobe_overlap", 32'(overlap), 32'd0);
        check("idle_zero", 32'(leak), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_psum_stream.md
ROUTER_PSUM_STREAM -- requirements
Module: router_psum_stream

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): DATA_BITWIDTH, 16, psum word width; ADDR_BITWIDTH_GLB, 10, GLB address width; X_dim, 5, psum lanes per vector; FIFO_DEPTH, 4, buffered vectors (power of 2); PSUM_LOAD_ADDR, 0, region base; PSUM_REGION, 256, region size in words.
REQ-002 Ports (name direction width meaning): clk in 1 clock; reset in 1 reset; r_data_spad_psum in DATA_BITWIDTH*X_dim psum vector, lane 0 in LSBs; write_psum_ctrl in 1 vector valid; accum_mode in 1 accumulate flag, sampled with vector; psum_ready out 1 FIFO not full; glb_ready in 1 GLB accepts access; read_req_glb_psum out 1 GLB read request; r_addr_glb_psum out ADDR_BITWIDTH_GLB read address; r_data_glb_psum in DATA_BITWIDTH read data; write_en_glb_psum out 1 GLB write; w_addr_glb_psum out ADDR_BITWIDTH_GLB write address; w_data_glb_psum out DATA_BITWIDTH write data; busy out 1 FSM not IDLE or FIFO non-empty; overflow_err out 1 sticky dropped-vector flag.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 A vector plus its accum_mode bit SHALL be pushed when write_psum_ctrl=1 and psum_ready=1.
REQ-005 psum_ready SHALL equal (FIFO count != FIFO_DEPTH), combinational from registered count; a pop in the same cycle SHALL NOT make room for a push.
REQ-006 write_psum_ctrl=1 while psum_ready=0 SHALL drop the vector and set overflow_err until reset.
REQ-007 FSM states SHALL be IDLE, LOAD, WRITE, RD, ACC.
REQ-008 IDLE -> LOAD when FIFO non-empty; LOAD pops head into lane shift register, lane index=0, -> WRITE if stored mode=0 else RD.
REQ-009 WRITE: when glb_ready=1, assert write_en_glb_psum with w_data=current lane, w_addr=pointer; advance lane and pointer; when glb_ready=0, hold with write_en low.
REQ-010 RD: when glb_ready=1, assert read_req_glb_psum with r_addr=pointer, -> ACC; else hold, read_req low.
REQ-011 ACC: r_data_glb_psum is valid this cycle (1-cycle GLB read latency); write lane+r_data (modulo 2^DATA_BITWIDTH, no saturation) to pointer unconditionally, advance lane and pointer, -> RD unless last lane.
REQ-012 After lane X_dim-1 is written: -> LOAD if FIFO non-empty, else IDLE.
REQ-013 Pointer SHALL wrap from PSUM_LOAD_ADDR+PSUM_REGION-1 to PSUM_LOAD_ADDR.
REQ-014 Latency: push in cycle t into empty FIFO with FSM IDLE -> LOAD in t+2, first write_en in t+3 (overwrite, glb_ready=1).
REQ-015 Throughput with glb_ready=1: overwrite X_dim+1 cycles/vector back-to-back; accumulate 2*X_dim+1.
REQ-016 read_req_glb_psum and write_en_glb_psum SHALL never be high in the same cycle.
REQ-017 Addresses/data SHALL be 0 whenever their strobe is low.

Reset
REQ-018 Reset SHALL set FSM IDLE, FIFO empty, pointer=PSUM_LOAD_ADDR, lane=0, overflow_err=0, all strobes/addresses/data 0, busy=0, psum_ready=1.
REQ-019 Reset mid-vector SHALL discard the partial vector and all buffered vectors; no write in the cycle after reset.

Structure
REQ-020 Package router_psum_pkg SHALL hold the FSM state type and lane-index width constant ($clog2(X_dim)).
REQ-021 FIFO SHALL be sub-module psum_vec_fifo (width DATA_BITWIDTH*X_dim+1, depth FIFO_DEPTH, count output).
REQ-022 RTL SHALL be 120-400 lines total.

Verification (DATA=16, X_dim=5, base 0, region 256)
REQ-023 Push {5,4,3,2,1} mode 0 at t, glb_ready=1 -> writes 1..5 to addr 0..4 in cycles t+3..t+7, busy low at t+8.
REQ-024 GLB holds 10 at addr 5..9; push {1,1,1,1,0xFFFF} mode 1 -> reads alternate with writes, data 9,11,11,11,11 at addr 5..9.
REQ-025 Push 5 vectors back-to-back while glb_ready=0 -> psum_ready low after 4, 5th dropped, overflow_err=1; release -> exactly 20 writes.
REQ-026 Pointer at 254, one overwrite vector -> addresses 254,255,0,1,2.
REQ-027 glb_ready toggles 1/0 each cycle -> no lost or duplicated word, strobes never coincide; reset asserted after 2nd word -> no further writes, pointer back to 0.
